// File: rtl/beaver32rv_trace_pkg.sv
// Shared types and constants for the beaver32rv retirement-trace buffer.
package beaver32rv_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_STOPPED   = 2'd3
    } trace_state_t;

    localparam int RD_W    = 5;
    localparam int INSTR_W = 32;

endpackage

// File: rtl/beaver32rv_trace_fifo.sv
// Record FIFO with first-word-fall-through head and an overwrite-oldest write path.
module beaver32rv_trace_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     head_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             wr_en;
    logic             rd_adv;

    // An overwrite writes into the oldest slot and moves both pointers together.
    assign wr_en  = (push | overwrite) & ~flush;
    assign rd_adv = (pop | overwrite) & ~flush;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (wr_en)
                tail_next = tail_reg + PTR_W'(1);
            if (rd_adv)
                head_next = head_reg + PTR_W'(1);
            if (push && !pop)
                count_next = count_reg + CNT_W'(1);
            else if (!push && pop)
                count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[tail_reg] <= wr_data;
    end

    assign head_valid = (count_reg != '0);
    assign head_data  = head_valid ? mem[head_reg] : '0;
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign count      = count_reg;

endmodule

// File: rtl/beaver32rv_trace_buffer.sv
// Retirement-trace capture: arm/trigger FSM, cycle stamping and drop accounting
// in front of a record FIFO drained through a valid/ready port.
module beaver32rv_trace_buffer
    import beaver32rv_trace_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16,
    parameter int DROP_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     clear,
    input  logic                     wrap_mode,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    input  logic                     ret_valid,
    input  logic [XLEN-1:0]          ret_pc,
    input  logic [XLEN-1:0]          ret_wdata,
    input  logic [INSTR_W-1:0]       ret_instr,
    input  logic [RD_W-1:0]          ret_rd,
    input  logic                     ret_regwrite,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CYCLE_W-1:0]       out_cycle,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_wdata,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [RD_W-1:0]          out_rd,
    output logic                     out_regwrite,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DROP_W-1:0]        dropped,
    output logic                     triggered
);

    localparam int REC_W = CYCLE_W + XLEN + INSTR_W + RD_W + XLEN + 1;

    trace_state_t      state_reg, state_next;
    logic [CYCLE_W-1:0] cycle_reg;
    logic [XLEN-1:0]    trig_pc_reg;
    logic               wrap_reg;
    logic [DROP_W-1:0]  dropped_reg;
    logic               triggered_reg;

    logic               flush;
    logic               pop;
    logic               fifo_push;
    logic               fifo_over;
    logic               fifo_full;
    logic               drop_inc;
    logic               trig_hit;
    logic [REC_W-1:0]   wr_rec;
    logic [REC_W-1:0]   head_rec;

    assign flush  = arm | clear;
    assign pop    = out_valid & out_ready & ~flush;
    assign wr_rec = {cycle_reg, ret_pc, ret_instr, ret_rd, ret_wdata, ret_regwrite};

    always_comb begin
        state_next = state_reg;
        fifo_push  = 1'b0;
        fifo_over  = 1'b0;
        drop_inc   = 1'b0;
        trig_hit   = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
        end else if (arm) begin
            state_next = trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
        end else begin
            unique case (state_reg)
                ST_WAIT_TRIG: begin
                    // The FIFO is empty here: arm flushed it and nothing was pushed since.
                    if (ret_valid && ret_pc == trig_pc_reg) begin
                        fifo_push  = 1'b1;
                        trig_hit   = 1'b1;
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (ret_valid) begin
                        if (fifo_full && !pop) begin
                            drop_inc = 1'b1;
                            if (wrap_reg)
                                fifo_over = 1'b1;
                            else
                                state_next = ST_STOPPED;
                        end else begin
                            fifo_push = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cycle_reg     <= '0;
            trig_pc_reg   <= '0;
            wrap_reg      <= 1'b0;
            dropped_reg   <= '0;
            triggered_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cycle_reg <= cycle_reg + CYCLE_W'(1);
            if (arm && !clear) begin
                trig_pc_reg <= trig_pc;
                wrap_reg    <= wrap_mode;
            end
            if (flush)
                dropped_reg <= '0;
            else if (drop_inc && dropped_reg != '1)
                dropped_reg <= dropped_reg + DROP_W'(1);
            if (flush)
                triggered_reg <= 1'b0;
            else if (trig_hit)
                triggered_reg <= 1'b1;
        end
    end

    beaver32rv_trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (fifo_push),
        .pop        (pop),
        .overwrite  (fifo_over),
        .wr_data    (wr_rec),
        .head_data  (head_rec),
        .head_valid (out_valid),
        .full       (fifo_full),
        .count      (count)
    );

    assign {out_cycle, out_pc, out_instr, out_rd, out_wdata, out_regwrite} = head_rec;
    assign state     = state_reg;
    assign dropped   = dropped_reg;
    assign triggered = triggered_reg;

endmodule

// File: tb/tb_beaver32rv_trace_buffer.sv
// Directed bench for the retirement-trace buffer: reset, trigger, stop and wrap modes.
module tb_beaver32rv_trace_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, clear, wrap_mode, trig_en;
    logic [31:0] trig_pc;
    logic        ret_valid;
    logic [31:0] ret_pc, ret_wdata, ret_instr;
    logic [4:0]  ret_rd;
    logic        ret_regwrite;
    logic        out_valid, out_ready;
    logic [15:0] out_cycle;
    logic [31:0] out_pc, out_wdata, out_instr;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic [1:0]  state;
    logic [4:0]  count;
    logic [7:0]  dropped;
    logic        triggered;

    int errors = 0;
    int checks = 0;
    int ncyc;

    beaver32rv_trace_buffer dut (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear), .wrap_mode(wrap_mode),
        .trig_en(trig_en), .trig_pc(trig_pc), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_wdata(ret_wdata), .ret_instr(ret_instr), .ret_rd(ret_rd),
        .ret_regwrite(ret_regwrite), .out_valid(out_valid), .out_ready(out_ready),
        .out_cycle(out_cycle), .out_pc(out_pc), .out_wdata(out_wdata),
        .out_instr(out_instr), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .state(state), .count(count), .dropped(dropped), .triggered(triggered)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release: the stamp a retirement driven now should carry.
    always @(posedge clk or negedge rst)
        if (!rst) ncyc <= 0;
        else      ncyc <= ncyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic wm, input logic te, input logic [31:0] tp);
        arm = 1'b1; wrap_mode = wm; trig_en = te; trig_pc = tp;
        tick;
        arm = 1'b0; wrap_mode = 1'b0; trig_en = 1'b0; trig_pc = '0;
        $display("arm wrap=%0d trig_en=%0d trig_pc=%0h -> state=%0d", wm, te, tp, state);
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd,
                          input logic [31:0] wd, input logic rw, output logic [15:0] stamp);
        ret_valid = 1'b1; ret_pc = pc; ret_rd = rd; ret_wdata = wd; ret_regwrite = rw;
        ret_instr = {20'h0, rd, 7'h33};
        stamp = 16'(ncyc);
        tick;
        ret_valid = 1'b0;
        $display("retire pc=%0h stamp=%0d -> count=%0d dropped=%0d state=%0d",
                 pc, stamp, count, dropped, state);
    endtask

    task automatic pop_one;
        $display("pop pc=%0h cycle=%0d rd=%0d", out_pc, out_cycle, out_rd);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    logic [15:0] st [3];
    logic [15:0] dummy;
    logic [31:0] pcs [3];
    logic [4:0]  rds [3];
    logic [31:0] wds [3];
    logic        rws [3];

    initial begin
        rst = 1'b1;
        arm = 0; clear = 0; wrap_mode = 0; trig_en = 0; trig_pc = '0;
        ret_valid = 0; ret_pc = '0; ret_wdata = '0; ret_instr = '0; ret_rd = '0;
        ret_regwrite = 0; out_ready = 0;
        #1 rst = 1'b0;
        #2;
        chk("reset_state", state, 0);
        chk("reset_count", count, 0);
        chk("reset_dropped", dropped, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_pc", out_pc, 0);
        #10 rst = 1'b1;

        // Plain capture of three records, then in-order readout.
        do_arm(1'b0, 1'b0, 32'h0);
        chk("arm_capture_state", state, 2);
        pcs = '{32'h0, 32'h4, 32'h8};
        rds = '{5'd1, 5'd2, 5'd3};
        wds = '{32'hA0, 32'hB1, 32'hC2};
        rws = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            retire(pcs[i], rds[i], wds[i], rws[i], st[i]);
            if (i == 0) chk("fwft_valid", out_valid, 1);
        end
        chk("three_count", count, 3);
        for (int i = 0; i < 3; i++) begin
            chk("pop_pc", out_pc, pcs[i]);
            chk("pop_cycle", out_cycle, st[i]);
            chk("pop_rd", out_rd, rds[i]);
            chk("pop_wdata", out_wdata, wds[i]);
            chk("pop_regwrite", out_regwrite, rws[i]);
            chk("pop_instr", out_instr, {20'h0, rds[i], 7'h33});
            pop_one;
        end
        chk("drained_count", count, 0);
        chk("drained_valid", out_valid, 0);

        // PC-match trigger.
        do_arm(1'b0, 1'b1, 32'h10);
        chk("trig_wait_state", state, 1);
        retire(32'h0, 5'd4, 32'h1, 1'b1, dummy);
        retire(32'h4, 5'd5, 32'h2, 1'b1, dummy);
        chk("trig_pre_count", count, 0);
        chk("trig_pre_state", state, 1);
        retire(32'h10, 5'd6, 32'h3, 1'b1, dummy);
        retire(32'h14, 5'd7, 32'h4, 1'b1, dummy);
        chk("trig_head_pc", out_pc, 32'h10);
        chk("trig_count", count, 2);
        chk("trig_triggered", triggered, 1);
        chk("trig_dropped", dropped, 0);
        chk("trig_state", state, 2);

        // Asynchronous reset in the middle of a capture.
        do_arm(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++)
            retire(32'h40 + 32'(4 * i), 5'd1, 32'(i), 1'b1, dummy);
        chk("pre_reset_count", count, 5);
        rst = 1'b0;
        #1;
        chk("async_reset_state", state, 0);
        chk("async_reset_count", count, 0);
        chk("async_reset_valid", out_valid, 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Stop-on-full: 18 retirements, first 16 kept.
        do_arm(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 18; i++)
            retire(32'h100 + 32'(4 * i), 5'(i), 32'(i), 1'b1, dummy);
        chk("stop_count", count, 16);
        chk("stop_dropped", dropped, 1);
        chk("stop_state", state, 3);
        for (int i = 0; i < 16; i++) begin
            chk("stop_pop_pc", out_pc, 32'h100 + 32'(4 * i));
            pop_one;
        end
        retire(32'h1FC, 5'd1, 32'h0, 1'b1, dummy);
        chk("stopped_no_capture", count, 0);
        chk("stopped_state", state, 3);

        // Wrap mode: 20 retirements, oldest four overwritten.
        do_arm(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++)
            retire(32'h200 + 32'(4 * i), 5'(i), 32'(i), 1'b1, dummy);
        chk("wrap_count", count, 16);
        chk("wrap_dropped", dropped, 4);
        chk("wrap_state", state, 2);
        chk("wrap_head_pc", out_pc, 32'h210);
        tick;
        chk("wrap_head_stable", out_pc, 32'h210);
        out_ready = 1'b1;
        retire(32'h300, 5'd9, 32'h99, 1'b1, dummy);
        out_ready = 1'b0;
        chk("full_pushpop_count", count, 16);
        chk("full_pushpop_dropped", dropped, 4);
        chk("full_pushpop_head", out_pc, 32'h214);
        for (int j = 0; j < 16; j++) begin
            chk("wrap_pop_pc", out_pc, (j < 15) ? 32'h214 + 32'(4 * j) : 32'h300);
            pop_one;
        end

        // clear beats a simultaneous arm.
        retire(32'h400, 5'd1, 32'h1, 1'b1, dummy);
        retire(32'h404, 5'd2, 32'h2, 1'b1, dummy);
        chk("preclear_count", count, 2);
        arm = 1'b1; clear = 1'b1;
        tick;
        arm = 1'b0; clear = 1'b0;
        $display("clear+arm -> state=%0d count=%0d", state, count);
        chk("clear_state", state, 0);
        chk("clear_count", count, 0);
        chk("clear_valid", out_valid, 0);
        chk("clear_dropped", dropped, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beaver32rv_trace_buffer.md
# beaver32rv_trace_buffer

Hardware retirement-trace buffer for the beaver32rv core. It replaces printing register and PC state from the bench with an on-chip capture of per-instruction commit records. Each record holds the cycle stamp, PC, instruction, destination register and write-back data, stored in a parametrised FIFO. Capture is armed by a control port, can wait for a PC-match trigger, supports stop-on-full and wrap (overwrite-oldest) modes, and drains through a valid/ready readout port.

## Interface
- XLEN, 32, PC/data width
- DEPTH, 16, record slots; power of two, ≥2
- CYCLE_W, 16, cycle-stamp width
- DROP_W, 8, dropped-record counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- arm  in  1  one-cycle pulse; flush and start a capture session
- clear  in  1  one-cycle pulse; flush and go idle; priority over arm
- wrap_mode  in  1  0 = stop on full, 1 = overwrite oldest; sampled on arm
- trig_en  in  1  wait for PC match before capturing; sampled on arm
- trig_pc  in  XLEN  trigger PC; sampled on arm
- ret_valid  in  1  an instruction retires this cycle
- ret_pc, ret_wdata  in  XLEN  retired PC, write-back data
- ret_instr  in  32  retired instruction
- ret_rd  in  5  destination register (instruction[11:7])
- ret_regwrite  in  1  RegWrite of retired instruction
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head
- out_cycle  out  CYCLE_W; out_pc, out_wdata  out  XLEN; out_instr  out  32; out_rd  out  5; out_regwrite  out  1  head record fields
- state  out  2  IDLE=0, WAIT_TRIG=1, CAPTURE=2, STOPPED=3
- count  out  $clog2(DEPTH)+1  records held
- dropped  out  DROP_W  records lost; saturates at all-ones
- triggered  out  1  trigger has fired this session

## Operation
- Cycle counter is free-running, increments every clk, wraps mod 2^CYCLE_W. A record is stamped with the counter value of its retire cycle.
- Push condition: ret_valid high in CAPTURE, or the trigger cycle in WAIT_TRIG.
- IDLE: arm goes to WAIT_TRIG if trig_en, else CAPTURE.
- WAIT_TRIG: ret_valid && ret_pc==trig_pc_q captures that record, sets triggered and goes to CAPTURE. Other retirements are ignored and not counted as dropped.
- CAPTURE, full with push and no pop:
  - wrap_mode_q=0: record is discarded, dropped+1, state goes to STOPPED.
  - wrap_mode_q=1: oldest record is discarded (head advances), new record is written, dropped+1, count stays DEPTH.
- Push and pop in the same cycle while full: both happen, count unchanged, no drop.
- STOPPED: no capture; readout continues; only arm or clear leave the state.
- arm in any state: flush FIFO, zero count/dropped/triggered, resample mode/trigger, enter WAIT_TRIG or CAPTURE. A retirement in the arm cycle is not captured.
- clear: flush, zero counters, go to IDLE. Wins over a simultaneous arm.
- Pop (out_valid && out_ready) is legal in every state.

## Timing
- Reset (rst low, async): state=IDLE, count=0, dropped=0, triggered=0, out_valid=0, cycle counter=0, pointers=0, trigger/mode registers=0. Output record fields are don't-care while out_valid=0 and are driven 0 after reset.
- First-word-fall-through readout: a push at edge N gives out_valid=1 and the head fields after edge N.
- Head fields stay stable while out_valid && !out_ready. The one exception is a wrap-mode overwrite, where the head advances to the next-oldest record.
- State, count, dropped and triggered are registered; each updates on the edge that performs the event.
- Pointers wrap mod DEPTH; count ranges over 0..DEPTH.

## Structure
- Package beaver32rv_trace_pkg holds the trace_state_t enum (2-bit encodings above) and the RD_W=5 and INSTR_W=32 constants.
- Sub-module beaver32rv_trace_fifo holds the storage array, head/tail pointers and count. It has push, pop and overwrite inputs and a FWFT head output. The top level contains the FSM, trigger compare, cycle counter and dropped counter.

## Test plan
- Reset mid-capture (count=5): rst low → state=0, count=0, out_valid=0 immediately, without waiting for a clk edge.
- arm with trig_en=0 and DEPTH=16, 3 retirements at pc 0,4,8 → count=3; popped in order pc 0,4,8, each with the correct cycle stamp and rd/wdata.
- trig_en=1, trig_pc=0x10, retirements at pc 0x0,0x4,0x10,0x14 → first record pc=0x10, count=2, triggered=1, dropped=0.
- Stop mode, 18 retirements with no pop → count=16, dropped=1, state=STOPPED; records hold the first 16 PCs.
- Wrap mode, 20 retirements with no pop → count=16, dropped=4, state=CAPTURE; head is the 5th retirement. Then, at full, push+pop in the same cycle → count=16, dropped unchanged.
- clear and arm pulsed together in CAPTURE → state=IDLE, count=0.
